key_expansion_ctrl: RTL

KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

---
 rtl/aes_pkg.sv | 17 +
 rtl/key_round_step.sv | 27 ++
 rtl/key_expansion_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the key-expansion controller state encoding.
package aes_pkg;

  localparam int BYTE            = 8;
  localparam int WORD            = 32;
  localparam int KEY_BITS        = 128;
  localparam int ROUNDNUMREPBITS = 4;
  localparam int NUM_ROUNDS      = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } kx_state_t;

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-schedule step: four new words from the current four, given
// the externally computed SubWord(RotWord(w3)) and the RCON word.
module key_round_step
  import aes_pkg::*;
(
  input  logic [WORD-1:0] w0,
  input  logic [WORD-1:0] w1,
  input  logic [WORD-1:0] w2,
  input  logic [WORD-1:0] w3,
  input  logic [WORD-1:0] sub_word_out,
  input  logic [WORD-1:0] rcon_in,
  output logic [WORD-1:0] n0,
  output logic [WORD-1:0] n1,
  output logic [WORD-1:0] n2,
  output logic [WORD-1:0] n3
);

  logic [WORD-1:0] t;

  // Only the top RCON byte is meaningful; the lower bytes are forced to zero.
  assign t  = sub_word_out ^ {rcon_in[WORD-1 -: BYTE], {(WORD-BYTE){1'b0}}};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

endmodule

// File: rtl/key_expansion_ctrl.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one at a time over a
// valid/ready handshake, sharing an external S-box and RCON source.
module key_expansion_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KEY_BITS-1:0]        cipherKey,
  output logic [ROUNDNUMREPBITS-1:0] roundNumber,
  input  logic [WORD-1:0]            rconIn,
  output logic [WORD-1:0]            subWordIn,
  input  logic [WORD-1:0]            subWordOut,
  output logic [KEY_BITS-1:0]        roundKey,
  output logic [ROUNDNUMREPBITS-1:0] keyRound,
  output logic                       keyValid,
  input  logic                       keyReady,
  output logic                       busy,
  output logic                       done,
  output kx_state_t                  state
);

  localparam logic [ROUNDNUMREPBITS-1:0] LAST_ROUND = ROUNDNUMREPBITS'(NUM_ROUNDS);

  logic [WORD-1:0] w0, w1, w2, w3;
  logic [WORD-1:0] n0, n1, n2, n3;

  assign w0 = roundKey[KEY_BITS-1        -: WORD];
  assign w1 = roundKey[KEY_BITS-1-WORD   -: WORD];
  assign w2 = roundKey[KEY_BITS-1-2*WORD -: WORD];
  assign w3 = roundKey[WORD-1:0];

  assign subWordIn = {w3[WORD-BYTE-1:0], w3[WORD-1 -: BYTE]};

  key_round_step u_step (
    .w0           (w0),
    .w1           (w1),
    .w2           (w2),
    .w3           (w3),
    .sub_word_out (subWordOut),
    .rcon_in      (rconIn),
    .n0           (n0),
    .n1           (n1),
    .n2           (n2),
    .n3           (n3)
  );

  // Handshake: a round key transfers on any rising edge where keyValid and
  // keyReady are both 1; roundKey/keyRound hold while keyValid=1 and keyReady=0.
  // roundNumber is registered alongside the move into EXPAND so the external
  // RCON lookup sees the right index during that cycle, and reads 1 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      roundKey    <= '0;
      keyRound    <= '0;
      roundNumber <= ROUNDNUMREPBITS'(1);
      keyValid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            roundKey <= cipherKey;
            keyRound <= '0;
            keyValid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (keyReady) begin
            keyValid <= 1'b0;
            if (keyRound < LAST_ROUND) begin
              roundNumber <= keyRound + ROUNDNUMREPBITS'(1);
              state       <= EXPAND;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        EXPAND: begin
          roundKey    <= {n0, n1, n2, n3};
          keyRound    <= keyRound + ROUNDNUMREPBITS'(1);
          roundNumber <= ROUNDNUMREPBITS'(1);
          keyValid    <= 1'b1;
          state       <= EMIT;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          keyValid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
